machine_ctrl: RTL and testbench

MACHINE_CTRL -- requirements
Module: machine_ctrl

---
 rtl/machine_ctrl.sv | 105 ++++++++++
 tb/tb_machine_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/machine_ctrl.sv
// Eight-step instruction sequencer for a simple accumulator CPU.
// Each enabled clock edge registers the control outputs for the current step.
module machine_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       inc_pc,
  output logic       load_acc,
  output logic       load_pc,
  output logic       rd,
  output logic       wr,
  output logic       load_ir,
  output logic       datactl_ena,
  output logic       halt
);

  typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5, S6, S7} step_t;
  typedef enum logic [2:0] {HLT, SKZ, ADD, ANDD, XORR, LDA, STO, JMP} opcode_t;

  step_t st;
  logic  halted;
  logic  is_alu_op;

  assign is_alu_op = (opcode == ADD) || (opcode == ANDD) ||
                     (opcode == XORR) || (opcode == LDA);

  // Outputs default to 0 on every executed step; the case only raises the active strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= S0;
      halted      <= 1'b0;
      inc_pc      <= 1'b0;
      load_acc    <= 1'b0;
      load_pc     <= 1'b0;
      rd          <= 1'b0;
      wr          <= 1'b0;
      load_ir     <= 1'b0;
      datactl_ena <= 1'b0;
      halt        <= 1'b0;
    end else if (halted) begin
      inc_pc      <= 1'b0;
      load_acc    <= 1'b0;
      load_pc     <= 1'b0;
      rd          <= 1'b0;
      wr          <= 1'b0;
      load_ir     <= 1'b0;
      datactl_ena <= 1'b0;
      halt        <= 1'b1;
    end else if (ena) begin
      inc_pc      <= 1'b0;
      load_acc    <= 1'b0;
      load_pc     <= 1'b0;
      rd          <= 1'b0;
      wr          <= 1'b0;
      load_ir     <= 1'b0;
      datactl_ena <= 1'b0;
      halt        <= 1'b0;
      st          <= step_t'(st + 3'd1);
      case (st)
        S0, S1: begin
          load_ir <= 1'b1;
          rd      <= 1'b1;
          inc_pc  <= 1'b1;
        end
        S3: begin
          if (opcode == HLT) begin
            halt   <= 1'b1;
            halted <= 1'b1;
          end
        end
        S4: begin
          if (opcode == JMP) load_pc <= 1'b1;
          if (opcode == STO) datactl_ena <= 1'b1;
          if (is_alu_op) rd <= 1'b1;
        end
        S5: begin
          if (is_alu_op) begin
            rd       <= 1'b1;
            load_acc <= 1'b1;
          end
          if ((opcode == SKZ) && zero) inc_pc <= 1'b1;
          if (opcode == JMP) begin
            load_pc <= 1'b1;
            inc_pc  <= 1'b1;
          end
          if (opcode == STO) begin
            wr          <= 1'b1;
            datactl_ena <= 1'b1;
          end
        end
        S6: begin
          if (opcode == STO) datactl_ena <= 1'b1;
          if (is_alu_op) rd <= 1'b1;
        end
        S7: begin
          if ((opcode == SKZ) && zero) inc_pc <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_machine_ctrl.sv
// Self-checking bench for machine_ctrl: directed instruction scenarios plus
// randomized traffic compared against a step/opcode table model.
module tb_machine_ctrl;

  localparam logic [2:0] OP_HLT = 3'b000, OP_SKZ = 3'b001, OP_ADD = 3'b010, OP_ANDD = 3'b011;
  localparam logic [2:0] OP_XORR = 3'b100, OP_LDA = 3'b101, OP_STO = 3'b110, OP_JMP = 3'b111;

  // Output vector bit masks: {inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt}
  localparam logic [7:0] F_INC = 8'h80, F_ACC = 8'h40, F_LPC = 8'h20, F_RD = 8'h10;
  localparam logic [7:0] F_WR = 8'h08, F_IR = 8'h04, F_DCE = 8'h02, F_HALT = 8'h01;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic [2:0] opcode = 3'b000;
  logic       zero = 1'b0;
  logic       inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt;
  logic [7:0] outs;

  int vectors = 0;
  int miscompares = 0;

  int         m_step = 0;
  bit         m_halted = 1'b0;
  logic [7:0] m_out = 8'h00;

  machine_ctrl dut (
    .clk(clk), .rst(rst), .ena(ena), .opcode(opcode), .zero(zero),
    .inc_pc(inc_pc), .load_acc(load_acc), .load_pc(load_pc), .rd(rd), .wr(wr),
    .load_ir(load_ir), .datactl_ena(datactl_ena), .halt(halt)
  );

  always #5 clk = ~clk;

  assign outs = {inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt};

  // What a step does for a given instruction, straight from the step table.
  function automatic logic [7:0] step_pattern(int step, logic [2:0] op, logic z);
    bit mem_op = (op == OP_ADD) || (op == OP_ANDD) || (op == OP_XORR) || (op == OP_LDA);
    logic [7:0] p = 8'h00;
    if (step == 0 || step == 1) p = F_IR | F_RD | F_INC;
    else if (step == 3 && op == OP_HLT) p = F_HALT;
    else if (step == 4) p = (op == OP_JMP) ? F_LPC : (op == OP_STO) ? F_DCE : mem_op ? F_RD : 8'h00;
    else if (step == 5) begin
      if (mem_op) p = F_RD | F_ACC;
      else if (op == OP_SKZ && z) p = F_INC;
      else if (op == OP_JMP) p = F_LPC | F_INC;
      else if (op == OP_STO) p = F_WR | F_DCE;
    end
    else if (step == 6) p = (op == OP_STO) ? F_DCE : mem_op ? F_RD : 8'h00;
    else if (step == 7 && op == OP_SKZ && z) p = F_INC;
    return p;
  endfunction

  // Advance one clock edge with the currently driven inputs and update the model.
  task automatic clock_edge();
    @(posedge clk);
    if (rst) begin
      m_step = 0; m_halted = 1'b0; m_out = 8'h00;
    end else if (m_halted) begin
      m_out = F_HALT;
    end else if (ena) begin
      m_out = step_pattern(m_step, opcode, zero);
      if (m_step == 3 && opcode == OP_HLT) m_halted = 1'b1;
      m_step = (m_step + 1) % 8;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ena = 1'b0;
    clock_edge();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b1; opcode = OP_LDA;
    clock_edge();
    vectors++;
    if (outs !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %h expected %h", outs, 8'h00);
    end
    rst = 1'b0;
    clock_edge();
    vectors++;
    if (outs !== (F_IR | F_RD | F_INC)) begin
      miscompares++;
      $display("[TB] FAIL reset_first_s0: got %h expected %h", outs, F_IR | F_RD | F_INC);
    end
  endtask

  task automatic test_lda();
    logic [7:0] exp_seq [9] = '{8'h94, 8'h94, 8'h00, 8'h00, 8'h10, 8'h50, 8'h10, 8'h00, 8'h94};
    do_reset();
    ena = 1'b1; opcode = OP_LDA; zero = 1'b0;
    for (int i = 0; i < 9; i++) begin
      clock_edge();
      vectors++;
      if (outs !== exp_seq[i] || outs !== m_out) begin
        miscompares++;
        $display("[TB] FAIL lda_step%0d: got %h expected %h", i % 8, outs, exp_seq[i]);
      end
    end
  endtask

  task automatic test_sto();
    do_reset();
    ena = 1'b1; opcode = OP_STO;
    for (int i = 0; i < 8; i++) begin
      clock_edge();
      vectors++;
      if (outs !== m_out) begin
        miscompares++;
        $display("[TB] FAIL sto_step%0d: got %h expected %h", i, outs, m_out);
      end
    end
  endtask

  task automatic test_skz();
    for (int z = 1; z >= 0; z--) begin
      do_reset();
      ena = 1'b1; opcode = OP_SKZ; zero = z[0];
      for (int i = 0; i < 8; i++) begin
        clock_edge();
        vectors++;
        if (outs !== m_out) begin
          miscompares++;
          $display("[TB] FAIL skz_z%0d_step%0d: got %h expected %h", z, i, outs, m_out);
        end
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_jmp();
    logic [7:0] exp_tail [4] = '{8'h20, 8'hA0, 8'h00, 8'h00};
    do_reset();
    ena = 1'b1; opcode = OP_JMP;
    for (int i = 0; i < 8; i++) begin
      clock_edge();
      vectors++;
      if (outs !== m_out || (i >= 4 && outs !== exp_tail[i-4])) begin
        miscompares++;
        $display("[TB] FAIL jmp_step%0d: got %h expected %h", i, outs, m_out);
      end
    end
  endtask

  task automatic test_halt();
    do_reset();
    ena = 1'b1; opcode = OP_HLT;
    for (int i = 0; i < 4; i++) clock_edge();
    vectors++;
    if (outs !== F_HALT) begin
      miscompares++;
      $display("[TB] FAIL halt_after_s3: got %h expected %h", outs, F_HALT);
    end
    opcode = OP_ADD;
    for (int i = 0; i < 20; i++) begin
      ena = i[0];
      zero = $urandom_range(0, 1);
      clock_edge();
      vectors++;
      if (outs !== F_HALT) begin
        miscompares++;
        $display("[TB] FAIL halt_hold%0d: got %h expected %h", i, outs, F_HALT);
      end
    end
    rst = 1'b1;
    clock_edge();
    vectors++;
    if (outs !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL halt_reset: got %h expected %h", outs, 8'h00);
    end
    rst = 1'b0; ena = 1'b1;
    clock_edge();
    vectors++;
    if (outs !== 8'h94) begin
      miscompares++;
      $display("[TB] FAIL halt_restart_s0: got %h expected %h", outs, 8'h94);
    end
  endtask

  task automatic test_stall_and_reset();
    do_reset();
    ena = 1'b1; opcode = OP_ADD;
    for (int i = 0; i < 6; i++) clock_edge();
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      opcode = 3'($urandom_range(0, 7));
      zero = $urandom_range(0, 1);
      clock_edge();
      vectors++;
      if (outs !== 8'h50) begin
        miscompares++;
        $display("[TB] FAIL stall_hold%0d: got %h expected %h", i, outs, 8'h50);
      end
    end
    ena = 1'b1; opcode = OP_ADD;
    clock_edge();
    vectors++;
    if (outs !== 8'h10) begin
      miscompares++;
      $display("[TB] FAIL stall_resume_s6: got %h expected %h", outs, 8'h10);
    end
    rst = 1'b1;
    clock_edge();
    vectors++;
    if (outs !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL mid_reset: got %h expected %h", outs, 8'h00);
    end
    rst = 1'b0;
    clock_edge();
    vectors++;
    if (outs !== 8'h94) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_s0: got %h expected %h", outs, 8'h94);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      ena = ($urandom_range(0, 9) < 7);
      opcode = 3'($urandom_range(0, 7));
      if (opcode == OP_HLT && $urandom_range(0, 1) == 1) opcode = OP_LDA;
      zero = $urandom_range(0, 1);
      clock_edge();
      vectors++;
      if (outs !== m_out || (rd && wr)) begin
        miscompares++;
        $display("[TB] FAIL random_cycle%0d: got %h expected %h", i, outs, m_out);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    $display("[TB] machine_ctrl bench start");
    test_reset();
    test_lda();
    test_sto();
    test_skz();
    test_jmp();
    test_halt();
    test_stall_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
